eth_pixel_receiver: RTL and testbench
=====================================

Name: eth_pixel_receiver

Overview:
- FPGA2-side RMII receive stage, directly downstream of the FPGA1 eth_packer transmit path.
- Samples crsdv/rxd dibits on the 50 MHz Ethernet clock, then:
  - strips preamble/SFD and the MAC header;
  - extracts a 16-bit packet index;
  - emits the payload as 8-bit pixels with absolute frame-buffer addresses for a 320x240 write port.
- FCS bytes are counted but not checked.

Parameters:
HEADER_BYTES, 14, MAC header bytes skipped after SFD
PIXELS_PER_PACKET, 320, payload pixel bytes per packet
PACKETS_PER_FRAME, 240, valid packet indices 0..PACKETS_PER_FRAME-1
FCS_BYTES, 4, trailing bytes counted, not written
ADDR_WIDTH, 17, pixel address width

Ports:
clk_in  input  1  50 MHz RMII reference clock
rst_n_in  input  1  asynchronous active-low reset
crsdv_in  input  1  RMII carrier sense / data valid
rxd_in  input  2  RMII receive dibit
pixel_out  output  8  received pixel byte
pixel_addr_out  output  ADDR_WIDTH  frame-buffer address of pixel_out
pixel_valid_out  output  1  single-cycle write strobe
frame_done_out  output  1  single-cycle pulse: last packet of frame fully written
err_out  output  1  single-cycle pulse: packet aborted or rejected
packet_count_out  output  16  count of good packets, wraps at 65535->0

Behaviour:
- Reset (rst_n_in low, async): state=IDLE; all counters 0; pixel_out=0, pixel_addr_out=0; pixel_valid_out, frame_done_out, err_out = 0; packet_count_out=0. Reset mid-packet discards the packet with no pulses.
- Byte assembly: dibits arrive LSB-first; byte = {d3,d2,d1,d0}, d0 sampled first. A dibit counter (0..3) runs only while crsdv_in=1 in HEADER/INDEX/PAYLOAD/TRAILER.
- Packet index: 2 bytes, big-endian, immediately after the header.
- States:
  - IDLE: crsdv_in=1 && rxd_in=01 -> PREAMBLE.
  - PREAMBLE: rxd_in=01 stays; rxd_in=11 (SFD tail) -> HEADER with all counters cleared; any other dibit, or crsdv_in=0 -> IDLE, no err.
  - HEADER: count HEADER_BYTES bytes, then -> INDEX.
  - INDEX: after 2 bytes, compute base = index*PIXELS_PER_PACKET (registered, one cycle, completes within the next byte time).
    - index >= PACKETS_PER_FRAME -> DROP with err_out pulse.
    - Otherwise -> PAYLOAD, k=0.
  - PAYLOAD: each completed byte, in the cycle after its 4th dibit:
    - pixel_valid_out=1 for 1 cycle, pixel_out=byte, pixel_addr_out=base+k; then k++.
    - Strobes are spaced exactly 4 cycles apart.
    - After byte k=PIXELS_PER_PACKET-1: packet_count_out++.
    - If index=PACKETS_PER_FRAME-1, frame_done_out pulses in the same cycle as the final strobe.
    - Then -> TRAILER.
  - TRAILER: count FCS_BYTES bytes; crsdv_in=0 -> IDLE. If crsdv_in=0 before FCS_BYTES are counted: err_out pulse, packet still counted good (pixels already written). Extra bytes after FCS are ignored.
  - DROP: no writes; crsdv_in=0 -> IDLE.
- crsdv_in=0 in HEADER/INDEX/PAYLOAD (runt):
  - err_out pulse, -> IDLE, partial byte discarded.
  - Pixels already strobed stay written; packet_count_out and frame_done_out unchanged.
- pixel_out and pixel_addr_out hold their last values between strobes.
- pixel_addr_out max = PACKETS_PER_FRAME*PIXELS_PER_PACKET-1 = 76799; the address never wraps within a packet.
- err_out and frame_done_out never pulse in the same cycle. A runt at the final byte boundary cannot occur: completion is checked before abort.
- Packets with out-of-order or repeated indices are accepted; the address is derived solely from the index.

Test Plan:
- Good packet, index 0, payload 0x00..0x3F repeating:
  - required: 320 strobes, 4 cycles apart, addr 0..319, data matches;
  - packet_count_out=1; no err; no frame_done.
- Packet index 239 (0x00EF), payload 0xA5:
  - required: addr 76480..76799, all data 0xA5;
  - frame_done_out pulses exactly once, coincident with the addr 76799 strobe.
- Packet index 240 (0x00F0): required: zero strobes, one err_out pulse, packet_count_out unchanged.
- crsdv_in drops after 100 payload bytes:
  - required: 100 strobes, one err_out pulse, state returns to IDLE;
  - the next good packet, index 5, writes addr 1600..1919 correctly.
- Preamble broken by dibit 00 before SFD: required: no strobes, no err; the following valid packet is received normally.
- rst_n_in asserted mid-PAYLOAD, async (between clock edges):
  - required: all outputs 0 immediately, no further strobes;
  - after release, the next packet is received from IDLE.

Source files
------------

// File: rtl/eth_pixel_receiver.sv
// RMII receive stage: assembles dibits into bytes, strips preamble/SFD and MAC header,
// and writes the payload of each indexed packet into a 320x240 frame buffer.
module eth_pixel_receiver #(
   parameter int HEADER_BYTES      = 14,
   parameter int PIXELS_PER_PACKET = 320,
   parameter int PACKETS_PER_FRAME = 240,
   parameter int FCS_BYTES         = 4,
   parameter int ADDR_WIDTH        = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  crsdv_in,
   input  logic [1:0]            rxd_in,
   output logic [7:0]            pixel_out,
   output logic [ADDR_WIDTH-1:0] pixel_addr_out,
   output logic                  pixel_valid_out,
   output logic                  frame_done_out,
   output logic                  err_out,
   output logic [15:0]           packet_count_out,
   output logic [2:0]            state_dbg_out
);

   // pixel_valid_out is a one-cycle write strobe with no backpressure; pixel_out and
   // pixel_addr_out are meaningful only in that cycle and hold their value otherwise.

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_HEADER   = 3'd2,
      S_INDEX    = 3'd3,
      S_PAYLOAD  = 3'd4,
      S_TRAILER  = 3'd5,
      S_DROP     = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            dcnt_q;
   logic [5:0]            shreg_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [7:0]            idx_hi_q;
   logic [15:0]           idx_q;
   logic [ADDR_WIDTH-1:0] base_q;

   logic        in_data, byte_done;
   logic [7:0]  byte_val;
   logic [15:0] idx_cat;
   logic        clr_cnt, inc_cnt, load_hi, load_idx;
   logic        strobe_d, done_pkt_d, frame_done_d, err_d;

   assign in_data   = (state_q == S_HEADER) || (state_q == S_INDEX) ||
                      (state_q == S_PAYLOAD) || (state_q == S_TRAILER);
   assign byte_done = in_data && crsdv_in && (dcnt_q == 2'd3);
   assign byte_val  = {rxd_in, shreg_q};
   assign idx_cat   = {idx_hi_q, byte_val};
   assign state_dbg_out = state_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      clr_cnt      = 1'b0;
      inc_cnt      = 1'b0;
      load_hi      = 1'b0;
      load_idx     = 1'b0;
      strobe_d     = 1'b0;
      done_pkt_d   = 1'b0;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (crsdv_in && rxd_in == 2'b01) state_d = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            if (!crsdv_in) state_d = S_IDLE;
            else if (rxd_in == 2'b11) begin
               state_d = S_HEADER;
               clr_cnt = 1'b1;
            end else if (rxd_in != 2'b01) state_d = S_IDLE;
         end
         S_HEADER: begin
            if (!crsdv_in) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (byte_done) begin
               if (cnt_q == CNT_W'(HEADER_BYTES - 1)) begin
                  state_d = S_INDEX;
                  clr_cnt = 1'b1;
               end else inc_cnt = 1'b1;
            end
         end
         S_INDEX: begin
            if (!crsdv_in) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (byte_done) begin
               if (cnt_q == '0) begin
                  load_hi = 1'b1;
                  inc_cnt = 1'b1;
               end else begin
                  load_idx = 1'b1;
                  clr_cnt  = 1'b1;
                  if (idx_cat >= 16'(PACKETS_PER_FRAME)) begin
                     state_d = S_DROP;
                     err_d   = 1'b1;
                  end else state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            // byte_done implies crsdv_in=1, so the final byte always completes first
            if (!crsdv_in) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (byte_done) begin
               strobe_d = 1'b1;
               if (cnt_q == CNT_W'(PIXELS_PER_PACKET - 1)) begin
                  done_pkt_d   = 1'b1;
                  frame_done_d = (idx_q == 16'(PACKETS_PER_FRAME - 1));
                  state_d      = S_TRAILER;
                  clr_cnt      = 1'b1;
               end else inc_cnt = 1'b1;
            end
         end
         S_TRAILER: begin
            if (!crsdv_in) begin
               state_d = S_IDLE;
               err_d   = (cnt_q < CNT_W'(FCS_BYTES));
            end else if (byte_done && cnt_q < CNT_W'(FCS_BYTES)) inc_cnt = 1'b1;
         end
         S_DROP: begin
            if (!crsdv_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         dcnt_q           <= '0;
         shreg_q          <= '0;
         cnt_q            <= '0;
         idx_hi_q         <= '0;
         idx_q            <= '0;
         base_q           <= '0;
         pixel_out        <= '0;
         pixel_addr_out   <= '0;
         pixel_valid_out  <= 1'b0;
         frame_done_out   <= 1'b0;
         err_out          <= 1'b0;
         packet_count_out <= '0;
      end else begin
         if (in_data && crsdv_in) begin
            dcnt_q  <= dcnt_q + 2'd1;
            shreg_q <= {rxd_in, shreg_q[5:2]};
         end else begin
            dcnt_q <= '0;
         end
         if (clr_cnt)      cnt_q <= '0;
         else if (inc_cnt) cnt_q <= cnt_q + CNT_W'(1);
         if (load_hi) idx_hi_q <= byte_val;
         if (load_idx) begin
            idx_q  <= idx_cat;
            base_q <= ADDR_WIDTH'(idx_cat) * ADDR_WIDTH'(PIXELS_PER_PACKET);
         end
         if (strobe_d) begin
            pixel_out      <= byte_val;
            pixel_addr_out <= base_q + ADDR_WIDTH'(cnt_q);
         end
         pixel_valid_out <= strobe_d;
         frame_done_out  <= frame_done_d;
         err_out         <= err_d;
         if (done_pkt_d) packet_count_out <= packet_count_out + 16'd1;
      end
   end

endmodule

// File: tb/tb_eth_pixel_receiver.sv
// Directed bench for eth_pixel_receiver: RMII packet driver, strobe capture monitor,
// and one task per scenario comparing captured strobes against hand-computed addresses.
module tb_eth_pixel_receiver;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        crsdv_in;
   logic [1:0]  rxd_in;
   logic [7:0]  pixel_out;
   logic [16:0] pixel_addr_out;
   logic        pixel_valid_out;
   logic        frame_done_out;
   logic        err_out;
   logic [15:0] packet_count_out;
   logic [2:0]  state_dbg_out;

   int tests_run    = 0;
   int tests_failed = 0;

   // capture state written by the monitor
   logic [16:0] cap_addr[$];
   logic [7:0]  cap_data[$];
   int          cap_cyc[$];
   int          cyc = 0;
   int          err_cnt = 0;
   int          fd_cnt = 0;
   int          both_cnt = 0;
   logic [16:0] fd_addr = '0;
   logic        fd_with_strobe = 1'b0;

   // expected queues built by each scenario
   logic [16:0] exp_addr[$];
   logic [7:0]  exp_data[$];

   int nbad;
   int gap_bad;

   eth_pixel_receiver dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .crsdv_in         (crsdv_in),
      .rxd_in           (rxd_in),
      .pixel_out        (pixel_out),
      .pixel_addr_out   (pixel_addr_out),
      .pixel_valid_out  (pixel_valid_out),
      .frame_done_out   (frame_done_out),
      .err_out          (err_out),
      .packet_count_out (packet_count_out),
      .state_dbg_out    (state_dbg_out)
   );

   always #10 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      cyc = cyc + 1;
      if (rst_n_in) begin
         if (pixel_valid_out) begin
            cap_addr.push_back(pixel_addr_out);
            cap_data.push_back(pixel_out);
            cap_cyc.push_back(cyc);
         end
         if (err_out) err_cnt = err_cnt + 1;
         if (frame_done_out) begin
            fd_cnt         = fd_cnt + 1;
            fd_addr        = pixel_addr_out;
            fd_with_strobe = pixel_valid_out;
         end
         if (err_out && frame_done_out) both_cnt = both_cnt + 1;
      end
   end

   task automatic clear_cap();
      cap_addr.delete();
      cap_data.delete();
      cap_cyc.delete();
      err_cnt = 0;
      fd_cnt  = 0;
   endtask

   // pat < 0 selects the repeating 0x00..0x3F ramp
   task automatic fill_exp(input int base, input int n, input int pat);
      exp_addr.delete();
      exp_data.delete();
      for (int k = 0; k < n; k++) begin
         exp_addr.push_back(17'(base + k));
         exp_data.push_back((pat < 0) ? 8'(k % 64) : 8'(pat));
      end
   endtask

   task automatic drive_dibit(input logic v, input logic [1:0] d);
      @(negedge clk_in);
      crsdv_in = v;
      rxd_in   = d;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 4; i++) drive_dibit(1'b1, b[2*i +: 2]);
   endtask

   task automatic send_start(input logic [15:0] idx);
      for (int i = 0; i < 7; i++) send_byte(8'h55);
      send_byte(8'hD5);
      for (int i = 0; i < 14; i++) send_byte(8'(i * 17 + 3));
      send_byte(idx[15:8]);
      send_byte(idx[7:0]);
   endtask

   task automatic send_payload(input int n, input int pat);
      for (int k = 0; k < n; k++) send_byte((pat < 0) ? 8'(k % 64) : 8'(pat));
   endtask

   task automatic send_end();
      @(negedge clk_in);
      crsdv_in = 1'b0;
      rxd_in   = 2'b00;
      repeat (8) @(negedge clk_in);
   endtask

   task automatic send_packet(input logic [15:0] idx, input int pat, input int nfcs);
      send_start(idx);
      send_payload(320, pat);
      for (int i = 0; i < nfcs; i++) send_byte(8'hC3);
      send_end();
   endtask

   task automatic test_reset();
      tests_run++;
      if (pixel_out !== 8'h00 || pixel_addr_out !== 17'd0) begin
         tests_failed++;
         $display("FAIL reset_data: pixel=%h addr=%0d, required 0/0", pixel_out, pixel_addr_out);
      end
      tests_run++;
      if ({pixel_valid_out, frame_done_out, err_out} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_pulses: v/fd/err=%b, required 000",
                  {pixel_valid_out, frame_done_out, err_out});
      end
      tests_run++;
      if (packet_count_out !== 16'd0 || state_dbg_out !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_state: count=%0d state=%0d, required 0/0", packet_count_out, state_dbg_out);
      end
   endtask

   task automatic test_good_idx0();
      clear_cap();
      send_packet(16'd0, -1, 4);
      fill_exp(0, 320, -1);
      tests_run++;
      if (cap_data.size() !== 320) begin
         tests_failed++;
         $display("FAIL idx0_count: strobes=%0d, required 320", cap_data.size());
      end
      nbad = 0;
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
         if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) nbad++;
      tests_run++;
      if (nbad !== 0) begin
         tests_failed++;
         $display("FAIL idx0_data: %0d mismatching strobes, required 0", nbad);
      end
      gap_bad = 0;
      for (int i = 1; i < cap_cyc.size(); i++) if (cap_cyc[i] - cap_cyc[i-1] !== 4) gap_bad++;
      tests_run++;
      if (gap_bad !== 0) begin
         tests_failed++;
         $display("FAIL idx0_spacing: %0d gaps not 4 cycles, required 0", gap_bad);
      end
      tests_run++;
      if (packet_count_out !== 16'd1 || err_cnt !== 0 || fd_cnt !== 0) begin
         tests_failed++;
         $display("FAIL idx0_status: count=%0d err=%0d fd=%0d, required 1/0/0",
                  packet_count_out, err_cnt, fd_cnt);
      end
   endtask

   task automatic test_last_packet();
      clear_cap();
      send_packet(16'h00EF, 8'hA5, 4);
      fill_exp(76480, 320, 8'hA5);
      nbad = (cap_data.size() == 320) ? 0 : 1000;
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
         if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) nbad++;
      tests_run++;
      if (nbad !== 0) begin
         tests_failed++;
         $display("FAIL last_data: strobes=%0d bad=%0d, required 320/0", cap_data.size(), nbad);
      end
      tests_run++;
      if (fd_cnt !== 1 || fd_with_strobe !== 1'b1 || fd_addr !== 17'd76799) begin
         tests_failed++;
         $display("FAIL last_frame_done: pulses=%0d strobe=%b addr=%0d, required 1/1/76799",
                  fd_cnt, fd_with_strobe, fd_addr);
      end
      tests_run++;
      if (packet_count_out !== 16'd2 || err_cnt !== 0) begin
         tests_failed++;
         $display("FAIL last_status: count=%0d err=%0d, required 2/0", packet_count_out, err_cnt);
      end
   endtask

   task automatic test_bad_index();
      clear_cap();
      send_packet(16'h00F0, -1, 4);
      tests_run++;
      if (cap_data.size() !== 0 || err_cnt !== 1 || packet_count_out !== 16'd2) begin
         tests_failed++;
         $display("FAIL bad_index: strobes=%0d err=%0d count=%0d, required 0/1/2",
                  cap_data.size(), err_cnt, packet_count_out);
      end
   endtask

   task automatic test_runt();
      clear_cap();
      send_start(16'd10);
      send_payload(100, -1);
      send_end();
      fill_exp(3200, 100, -1);
      nbad = (cap_data.size() == 100) ? 0 : 1000;
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
         if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) nbad++;
      tests_run++;
      if (nbad !== 0) begin
         tests_failed++;
         $display("FAIL runt_data: strobes=%0d bad=%0d, required 100/0", cap_data.size(), nbad);
      end
      tests_run++;
      if (err_cnt !== 1 || state_dbg_out !== 3'd0 || packet_count_out !== 16'd2 || fd_cnt !== 0) begin
         tests_failed++;
         $display("FAIL runt_status: err=%0d state=%0d count=%0d fd=%0d, required 1/0/2/0",
                  err_cnt, state_dbg_out, packet_count_out, fd_cnt);
      end
      clear_cap();
      send_packet(16'd5, -1, 4);
      fill_exp(1600, 320, -1);
      nbad = (cap_data.size() == 320) ? 0 : 1000;
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
         if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) nbad++;
      tests_run++;
      if (nbad !== 0 || packet_count_out !== 16'd3 || err_cnt !== 0) begin
         tests_failed++;
         $display("FAIL after_runt: strobes=%0d bad=%0d count=%0d err=%0d, required 320/0/3/0",
                  cap_data.size(), nbad, packet_count_out, err_cnt);
      end
   endtask

   task automatic test_broken_preamble();
      clear_cap();
      for (int i = 0; i < 3; i++) send_byte(8'h55);
      drive_dibit(1'b1, 2'b01);
      drive_dibit(1'b1, 2'b00);
      drive_dibit(1'b1, 2'b00);
      send_end();
      tests_run++;
      if (cap_data.size() !== 0 || err_cnt !== 0 || state_dbg_out !== 3'd0) begin
         tests_failed++;
         $display("FAIL broken_preamble: strobes=%0d err=%0d state=%0d, required 0/0/0",
                  cap_data.size(), err_cnt, state_dbg_out);
      end
      clear_cap();
      send_packet(16'd1, 8'h3C, 4);
      fill_exp(320, 320, 8'h3C);
      nbad = (cap_data.size() == 320) ? 0 : 1000;
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
         if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) nbad++;
      tests_run++;
      if (nbad !== 0 || packet_count_out !== 16'd4) begin
         tests_failed++;
         $display("FAIL after_preamble: strobes=%0d bad=%0d count=%0d, required 320/0/4",
                  cap_data.size(), nbad, packet_count_out);
      end
   endtask

   task automatic test_short_fcs();
      clear_cap();
      send_packet(16'd2, -1, 2);
      tests_run++;
      if (cap_data.size() !== 320 || err_cnt !== 1 || packet_count_out !== 16'd5 || fd_cnt !== 0) begin
         tests_failed++;
         $display("FAIL short_fcs: strobes=%0d err=%0d count=%0d fd=%0d, required 320/1/5/0",
                  cap_data.size(), err_cnt, packet_count_out, fd_cnt);
      end
   endtask

   task automatic test_async_reset();
      clear_cap();
      send_start(16'd3);
      send_payload(50, -1);
      drive_dibit(1'b1, 2'b10);
      drive_dibit(1'b1, 2'b01);
      tests_run++;
      if (cap_data.size() !== 50 || pixel_addr_out !== 17'd1009) begin
         tests_failed++;
         $display("FAIL pre_reset: strobes=%0d addr=%0d, required 50/1009", cap_data.size(), pixel_addr_out);
      end
      @(posedge clk_in);
      #3 rst_n_in = 1'b0;
      #1;
      tests_run++;
      if (pixel_out !== 8'h00 || pixel_addr_out !== 17'd0 || packet_count_out !== 16'd0 ||
          state_dbg_out !== 3'd0 || {pixel_valid_out, frame_done_out, err_out} !== 3'b000) begin
         tests_failed++;
         $display("FAIL async_reset: pixel=%h addr=%0d count=%0d state=%0d pulses=%b, required all 0",
                  pixel_out, pixel_addr_out, packet_count_out, state_dbg_out,
                  {pixel_valid_out, frame_done_out, err_out});
      end
      clear_cap();
      for (int i = 0; i < 6; i++) drive_dibit(1'b1, 2'(i));
      @(negedge clk_in);
      rst_n_in = 1'b1;
      for (int i = 0; i < 12; i++) drive_dibit(1'b1, 2'(i + 2));
      send_end();
      tests_run++;
      if (cap_data.size() !== 0 || err_cnt !== 0 || state_dbg_out !== 3'd0) begin
         tests_failed++;
         $display("FAIL post_reset_quiet: strobes=%0d err=%0d state=%0d, required 0/0/0",
                  cap_data.size(), err_cnt, state_dbg_out);
      end
      clear_cap();
      send_packet(16'd7, -1, 4);
      fill_exp(2240, 320, -1);
      nbad = (cap_data.size() == 320) ? 0 : 1000;
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++)
         if (cap_data[i] !== exp_data[i] || cap_addr[i] !== exp_addr[i]) nbad++;
      tests_run++;
      if (nbad !== 0 || packet_count_out !== 16'd1 || err_cnt !== 0) begin
         tests_failed++;
         $display("FAIL after_reset: strobes=%0d bad=%0d count=%0d err=%0d, required 320/0/1/0",
                  cap_data.size(), nbad, packet_count_out, err_cnt);
      end
   endtask

   initial begin
      rst_n_in = 1'b0;
      crsdv_in = 1'b0;
      rxd_in   = 2'b00;
      repeat (3) @(negedge clk_in);
      test_reset();
      rst_n_in = 1'b1;
      repeat (3) @(negedge clk_in);
      test_good_idx0();
      test_last_packet();
      test_bad_index();
      test_runt();
      test_broken_preamble();
      test_short_fcs();
      test_async_reset();
      tests_run++;
      if (both_cnt !== 0) begin
         tests_failed++;
         $display("FAIL err_fd_overlap: %0d cycles with both pulses, required 0", both_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
